// File: rtl/sma_inverse.sv
// Decoder for the TAPS-tap running-sum moving-average encoder: subtracts the
// sum of the last TAPS-1 recovered samples from each encoded sample, modulo 2^WIDTH.
module sma_inverse #(
    parameter int WIDTH = 16,
    parameter int TAPS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic                    y_valid,
    input  logic                    sync_clr,
    output logic signed [WIDTH-1:0] x_out,
    output logic                    x_valid,
    output logic                    hist_full,
    output logic [4:0]              fill_cnt
);

    localparam int         HD       = TAPS - 1;
    localparam logic [4:0] FULL_CNT = 5'(TAPS - 1);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // A two-tap encoder has a single history slot, so one sample already fills it.
    localparam logic [1:0] ST_FIRST   = (HD == 1) ? ST_RUN : ST_FILL;
    localparam logic       FIRST_FULL = (HD == 1) ? 1'b1 : 1'b0;

    function automatic logic signed [WIDTH-1:0] wrap_add(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        return a + b;
    endfunction

    function automatic logic signed [WIDTH-1:0] wrap_sub(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        return a - b;
    endfunction

    logic signed [WIDTH-1:0] hist [HD];
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] rec;
    logic [1:0]              state;
    logic [4:0]              next_cnt;

    always_comb begin
        acc = '0;
        for (int k = 0; k < HD; k++) begin
            acc = wrap_add(acc, hist[k]);
        end
        rec = wrap_sub(y_in, acc);
    end

    always_comb begin
        next_cnt = fill_cnt;
        if (fill_cnt < FULL_CNT) begin
            next_cnt = fill_cnt + 5'd1;
        end
    end

    // Register stage: recovered sample, history shift and fill tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < HD; k++) begin
                hist[k] <= '0;
            end
            x_out     <= '0;
            x_valid   <= 1'b0;
            hist_full <= 1'b0;
            fill_cnt  <= '0;
            state     <= ST_CLEAR;
        end else if (sync_clr) begin
            for (int k = 1; k < HD; k++) begin
                hist[k] <= '0;
            end
            if (y_valid) begin
                hist[0]   <= y_in;
                x_out     <= y_in;
                x_valid   <= 1'b1;
                fill_cnt  <= 5'd1;
                hist_full <= FIRST_FULL;
                state     <= ST_FIRST;
            end else begin
                hist[0]   <= '0;
                x_valid   <= 1'b0;
                fill_cnt  <= '0;
                hist_full <= 1'b0;
                state     <= ST_CLEAR;
            end
        end else if (y_valid) begin
            hist[0] <= rec;
            for (int k = 1; k < HD; k++) begin
                hist[k] <= hist[k-1];
            end
            x_out     <= rec;
            x_valid   <= 1'b1;
            fill_cnt  <= next_cnt;
            hist_full <= (next_cnt == FULL_CNT);
            case (state)
                ST_CLEAR: state <= ST_FIRST;
                ST_FILL:  state <= (next_cnt == FULL_CNT) ? ST_RUN : ST_FILL;
                ST_RUN:   state <= ST_RUN;
                default:  state <= ST_CLEAR;
            endcase
        end else begin
            x_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sma_inverse.sv
// Directed and loopback checks for the running-sum decoder.
module tb_sma_inverse;

    logic               clk;
    logic               rst;
    logic signed [15:0] y_in;
    logic               y_valid;
    logic               sync_clr;
    logic signed [15:0] x_out;
    logic               x_valid;
    logic               hist_full;
    logic [4:0]         fill_cnt;

    int ntests = 0;
    int nfail  = 0;

    sma_inverse #(.WIDTH(16), .TAPS(4)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .sync_clr(sync_clr),
        .x_out(x_out), .x_valid(x_valid), .hist_full(hist_full), .fill_cnt(fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int y, input logic v, input logic c);
        y_in     = 16'(y);
        y_valid  = v;
        sync_clr = c;
        cyc();
        y_valid  = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        y_valid = 1'b0;
        sync_clr = 1'b0;
        y_in = '0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        y_valid = 1'b0;
        sync_clr = 1'b0;
        y_in = 16'sd99;
        cyc();
        ntests++;
        if (x_out !== 16'sd0 || x_valid !== 1'b0 || hist_full !== 1'b0 || fill_cnt !== 5'd0) begin
            $display("FAIL reset: x_out=%0d x_valid=%b hist_full=%b fill_cnt=%0d, want all 0",
                     x_out, x_valid, hist_full, fill_cnt);
            nfail++;
        end
        rst = 1'b1;
    endtask

    task automatic run_basic(input string tag);
        int   ys[5]  = '{1, 3, 6, 10, 14};
        int   xs[5]  = '{1, 2, 3, 4, 5};
        int   fc[5]  = '{1, 2, 3, 3, 3};
        logic hf[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(ys[i], 1'b1, 1'b0);
            ntests++;
            if (x_out !== 16'(xs[i]) || x_valid !== 1'b1 || fill_cnt !== 5'(fc[i]) || hist_full !== hf[i]) begin
                $display("FAIL %s[%0d]: x_out=%0d x_valid=%b fill_cnt=%0d hist_full=%b, want %0d 1 %0d %b",
                         tag, i, x_out, x_valid, fill_cnt, hist_full, xs[i], fc[i], hf[i]);
                nfail++;
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        run_basic("basic");
    endtask

    task automatic test_wrap();
        int ys[5] = '{32767, -2, 32765, -4, -4};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(ys[i], 1'b1, 1'b0);
            ntests++;
            if (x_out !== 16'sd32767 || x_valid !== 1'b1) begin
                $display("FAIL wrap[%0d]: x_out=%0d x_valid=%b, want 32767 1", i, x_out, x_valid);
                nfail++;
            end
        end
    endtask

    task automatic check_idle(input string tag, input int hold);
        ntests++;
        if (x_valid !== 1'b0 || x_out !== 16'(hold)) begin
            $display("FAIL %s: x_valid=%b x_out=%0d, want 0 %0d", tag, x_valid, x_out, hold);
            nfail++;
        end
    endtask

    task automatic check_out(input string tag, input int want);
        ntests++;
        if (x_valid !== 1'b1 || x_out !== 16'(want)) begin
            $display("FAIL %s: x_valid=%b x_out=%0d, want 1 %0d", tag, x_valid, x_out, want);
            nfail++;
        end
    endtask

    task automatic test_gaps();
        do_reset();
        drive(1, 1'b1, 1'b0);
        check_out("gaps_x0", 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b0, 1'b0);
            check_idle("gaps_idle_a", 1);
        end
        drive(3, 1'b1, 1'b0);
        check_out("gaps_x1", 2);
        drive(0, 1'b0, 1'b0);
        check_idle("gaps_idle_b", 2);
        drive(6, 1'b1, 1'b0);
        check_out("gaps_x2", 3);
    endtask

    task automatic test_clear();
        do_reset();
        run_basic("clear_pre");
        drive(7, 1'b1, 1'b1);
        ntests++;
        if (x_out !== 16'sd7 || x_valid !== 1'b1 || fill_cnt !== 5'd1 || hist_full !== 1'b0) begin
            $display("FAIL clear_first: x_out=%0d x_valid=%b fill_cnt=%0d hist_full=%b, want 7 1 1 0",
                     x_out, x_valid, fill_cnt, hist_full);
            nfail++;
        end
        drive(15, 1'b1, 1'b0);
        ntests++;
        if (x_out !== 16'sd8 || x_valid !== 1'b1 || fill_cnt !== 5'd2 || hist_full !== 1'b0) begin
            $display("FAIL clear_second: x_out=%0d x_valid=%b fill_cnt=%0d hist_full=%b, want 8 1 2 0",
                     x_out, x_valid, fill_cnt, hist_full);
            nfail++;
        end
        // Clear without data, then a fresh sample must decode against zero history.
        drive(0, 1'b0, 1'b1);
        ntests++;
        if (x_valid !== 1'b0 || fill_cnt !== 5'd0 || hist_full !== 1'b0) begin
            $display("FAIL clear_only: x_valid=%b fill_cnt=%0d hist_full=%b, want 0 0 0",
                     x_valid, fill_cnt, hist_full);
            nfail++;
        end
        drive(9, 1'b1, 1'b0);
        check_out("clear_only_next", 9);
    endtask

    task automatic test_async_reset();
        do_reset();
        run_basic("areset_pre");
        #2 rst = 1'b0;
        #1;
        ntests++;
        if (x_out !== 16'sd0 || x_valid !== 1'b0 || fill_cnt !== 5'd0 || hist_full !== 1'b0) begin
            $display("FAIL areset_now: x_out=%0d x_valid=%b fill_cnt=%0d hist_full=%b, want 0 0 0 0",
                     x_out, x_valid, fill_cnt, hist_full);
            nfail++;
        end
        #2 rst = 1'b1;
        drive(5, 1'b1, 1'b0);
        check_out("areset_after", 5);
    endtask

    task automatic test_loopback();
        logic signed [15:0] e0, e1, e2, x, y;
        int errs;
        int timeout;
        e0 = '0; e1 = '0; e2 = '0;
        errs = 0;
        drive(0, 1'b0, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            timeout = 0;
            while ($urandom_range(0, 3) == 0 && timeout < 4) begin
                drive(0, 1'b0, 1'b0);
                timeout++;
                ntests++;
                if (x_valid !== 1'b0) begin
                    $display("FAIL loop_gap[%0d]: x_valid=%b, want 0", i, x_valid);
                    nfail++;
                end
            end
            x = 16'($urandom);
            y = x + e0 + e1 + e2;
            e2 = e1; e1 = e0; e0 = x;
            drive(int'(y), 1'b1, 1'b0);
            ntests++;
            if (x_valid !== 1'b1 || x_out !== x) begin
                if (errs < 10) begin
                    $display("FAIL loop[%0d]: x_out=%0d x_valid=%b, want %0d 1", i, x_out, x_valid, x);
                end
                errs++;
                nfail++;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        y_in = '0;
        y_valid = 1'b0;
        sync_clr = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_gaps();
        test_clear();
        test_async_reset();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/sma_inverse.md
Name: sma_inverse

Overview:
- Recovers the original sample stream from the output of the 4-tap running-sum moving-average filter; it is the decoder for that encoder.
- The encoder computes y[n] = x[n] + x[n-1] + x[n-2] + x[n-3] in modulo-2^WIDTH arithmetic with zeroed history. This block therefore computes x[n] = y[n] - (x[n-1] + x[n-2] + x[n-3]), which is exact under the same modular arithmetic.
- It sits at the receiving end of a link or loopback test path. It adds a valid qualifier, a history-clear input and a fill indicator.

Parameters:
- WIDTH, 16, sample width in bits for y_in and x_out; two's complement.
- TAPS, 4, encoder tap count. Legal range is 2..16. History depth is TAPS-1.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset.
- y_in, input, WIDTH signed, encoded running-sum sample.
- y_valid, input, 1, y_in is a valid sample this cycle.
- sync_clr, input, 1, synchronous history clear. Pulsed in the same cycle the encoder's history is zeroed.
- x_out, output, WIDTH signed, recovered sample, registered.
- x_valid, output, 1, x_out holds a new sample this cycle (single-cycle strobe).
- hist_full, output, 1, at least TAPS-1 samples decoded since the last clear.
- fill_cnt, output, 5, number of samples decoded since clear, saturating at TAPS-1.

Behaviour:
- Reset (rst = 0, asynchronous) clears the following to 0:
  - history registers h[0..TAPS-2]
  - x_out, x_valid, hist_full, fill_cnt
  - state, which goes to CLEAR.
- Release of reset is synchronised by the reset tree, not by this block.
- Datapath:
  - acc = sum of h[0..TAPS-2], truncated to WIDTH bits (modular).
  - rec = (y_in - acc), truncated to WIDTH bits.
  - No saturation anywhere. Wrap-around is required for exact inversion.
- On a y_valid cycle with sync_clr = 0:
  - x_out <= rec; x_valid <= 1.
  - The history shifts: h[0] <= rec, h[k] <= h[k-1].
- Latency: the sample presented at edge N appears on x_out and x_valid after edge N, i.e. 1 clock.
- On a cycle with y_valid = 0: x_valid <= 0; x_out holds its value; history holds.
- Gaps in y_valid are transparent. Decoding resumes with the held history.
- State machine:
  - CLEAR: history is all zero and fill_cnt = 0. The first y_valid moves to FILL, or directly to RUN when TAPS-1 = 1.
  - FILL: fill_cnt increments on each y_valid. On reaching TAPS-1, go to RUN and set hist_full = 1.
  - RUN: fill_cnt holds at TAPS-1 and hist_full = 1. Stays in RUN until a clear.
- sync_clr = 1 (any state):
  - Next cycle: history zeroed, fill_cnt = 0, hist_full = 0, state = CLEAR, x_valid = 0.
  - If y_valid is also 1, that y_in is treated as the first sample after the clear, using zero history:
    - x_out <= y_in, x_valid <= 1
    - h[0] <= y_in, other h = 0
    - fill_cnt = 1, state = FILL (or RUN when TAPS-1 = 1).
  - sync_clr takes priority over history from before the clear.
- Reset mid-stream: all outputs drop to 0 immediately, asynchronously. The first post-reset y_valid is decoded against zero history.
- x_out is valid only in the cycles where x_valid = 1.
- hist_full is informational only. Decoded values are exact from the first sample, provided the encoder started from zeroed history.

Test Plan:
- Basic recovery, WIDTH = 16, TAPS = 4.
  - Stimulus: after reset, y_in = 1, 3, 6, 10, 14 on consecutive valid cycles.
  - Required: x_out = 1, 2, 3, 4, 5, each with x_valid, 1 cycle later.
  - Required: fill_cnt = 1, 2, 3, 3, 3; hist_full rises with the 3rd output.
- Wrap-around.
  - Stimulus: y_in = 32767, -2, 32765, -4, -4.
  - Required: x_out = 32767 on all five outputs.
- Valid gaps.
  - Stimulus: y = 1, idle 3 cycles, 3, idle, 6.
  - Required: x_out = 1, 2, 3. x_valid is low during the idle cycles and x_out holds its last value.
- Clear with data.
  - Stimulus: run the basic sequence, then sync_clr = 1 and y_valid = 1 with y_in = 7, followed by y_in = 15.
  - Required: x_out = 7 then 8; fill_cnt = 1 then 2; hist_full = 0 after the clear.
- Async reset mid-stream.
  - Stimulus: assert rst low between clock edges during RUN.
  - Required: x_out = 0, x_valid = 0, fill_cnt = 0 immediately. After release, y_in = 5 produces x_out = 5.
- Loopback.
  - Stimulus: feed 1000 random 16-bit samples through the encoder, then this block, with random y_valid gaps applied to both.
  - Required: output equals input with exact bit match.
